// File: rtl/sync_pkg.sv
// Shared constants and helpers for the clock-domain synchroniser family.
package sync_pkg;

  localparam int STAGES_MIN = 2;
  localparam int STAGES_MAX = 4;

  // Bits needed to count 0..n; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sync_deglitch.sv
// One channel of stability filtering plus registered rise/fall pulses.
// Edge pulses exist only when SYNC_FILT_EDGE_EN is defined; otherwise they are tied low.
module sync_deglitch
  import sync_pkg::*;
#(
  parameter int   FILT_CNT = 4,
  parameter logic RST_VAL  = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sync_i,
  output logic filt_o,
  output logic rise_o,
  output logic fall_o
);

  logic filt_d, filt_q;

  if (FILT_CNT == 0) begin : g_bypass
    assign filt_d = sync_i;
  end else begin : g_filt
    localparam int            CW   = cnt_w(FILT_CNT);
    localparam logic [CW-1:0] LAST = CW'(FILT_CNT - 1);
    logic [CW-1:0] cnt_d, cnt_q;

    // Any agreeing cycle drops the count, so only N back-to-back disagreements flip the output.
    always_comb begin
      filt_d = filt_q;
      cnt_d  = '0;
      if (sync_i != filt_q) begin
        if (cnt_q == LAST) begin
          filt_d = sync_i;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= RST_VAL;
    end else begin
      filt_q <= filt_d;
    end
  end

  assign filt_o = filt_q;

`ifdef SYNC_FILT_EDGE_EN
  logic rise_q, fall_q;

  // Pulses are computed from the next filtered value so they line up with filt_o changing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= filt_d & ~filt_q;
      fall_q <= ~filt_d & filt_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
`else
  assign rise_o = 1'b0;
  assign fall_o = 1'b0;
`endif

endmodule

// File: rtl/sync_filter_multi.sv
// Multi-channel synchroniser with per-channel glitch filter and edge pulses.
// Optional feature macro: SYNC_FILT_EDGE_EN (enables rise_p/fall_p/change_p).
module sync_filter_multi
  import sync_pkg::*;
#(
  parameter int                  CHANNELS = 4,
  parameter int                  STAGES   = 2,
  parameter int                  FILT_CNT = 4,
  parameter logic [CHANNELS-1:0] RST_VAL  = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] async_in,
  output logic [CHANNELS-1:0] sync_out,
  output logic [CHANNELS-1:0] filt_out,
  output logic [CHANNELS-1:0] rise_p,
  output logic [CHANNELS-1:0] fall_p,
  output logic                change_p
);

  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
    $error("sync_filter_multi: STAGES must be within 2..4");
  end

  logic [CHANNELS-1:0] stage_q [STAGES];

  // Plain flop chain; stage 0 is the only flop that can go metastable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        stage_q[k] <= RST_VAL;
      end
    end else begin
      stage_q[0] <= async_in;
      for (int k = 1; k < STAGES; k++) begin
        stage_q[k] <= stage_q[k-1];
      end
    end
  end

  assign sync_out = stage_q[STAGES-1];

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    sync_deglitch #(
      .FILT_CNT (FILT_CNT),
      .RST_VAL  (RST_VAL[i])
    ) u_deglitch (
      .clk    (clk),
      .rst_n  (rst_n),
      .sync_i (sync_out[i]),
      .filt_o (filt_out[i]),
      .rise_o (rise_p[i]),
      .fall_o (fall_p[i])
    );
  end

  assign change_p = |(rise_p | fall_p);

endmodule

// File: tb/tb_sync_filter_multi.sv
// Self-checking bench: one filtered instance and one bypass instance against a behavioural model.
module tb_sync_filter_multi;

`ifdef SYNC_FILT_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  localparam int NCFG = 2;

  logic       clk;
  logic       rst_n;
  logic [3:0] async_in;

  logic [3:0] sync_f, filt_f, rise_f, fall_f;
  logic       chg_f;
  logic [3:0] sync_b, filt_b, rise_b, fall_b;
  logic       chg_b;

  int checks = 0;
  int errors = 0;

  sync_filter_multi #(.CHANNELS(4), .STAGES(2), .FILT_CNT(4), .RST_VAL(4'b1010)) dut_f (
    .clk(clk), .rst_n(rst_n), .async_in(async_in),
    .sync_out(sync_f), .filt_out(filt_f), .rise_p(rise_f), .fall_p(fall_f), .change_p(chg_f)
  );

  sync_filter_multi #(.CHANNELS(4), .STAGES(3), .FILT_CNT(0), .RST_VAL(4'b0000)) dut_b (
    .clk(clk), .rst_n(rst_n), .async_in(async_in),
    .sync_out(sync_b), .filt_out(filt_b), .rise_p(rise_b), .fall_p(fall_b), .change_p(chg_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: history of sampled inputs, run length of disagreement per channel.
  int         m_s  [NCFG] = '{2, 3};
  int         m_n  [NCFG] = '{4, 0};
  logic [3:0] m_rv [NCFG] = '{4'b1010, 4'b0000};
  logic [3:0] hist [NCFG][4];
  int         run  [NCFG][4];
  logic [3:0] m_sync [NCFG];
  logic [3:0] m_filt [NCFG];
  logic [3:0] m_rise [NCFG];
  logic [3:0] m_fall [NCFG];
  logic [3:0] old_sync, old_filt, new_filt;

  always @(posedge clk or negedge rst_n) begin
    for (int c = 0; c < NCFG; c++) begin
      if (!rst_n) begin
        for (int k = 0; k < 4; k++) begin
          hist[c][k] = m_rv[c];
          run[c][k]  = 0;
        end
        m_sync[c] = m_rv[c];
        m_filt[c] = m_rv[c];
        m_rise[c] = 4'b0000;
        m_fall[c] = 4'b0000;
      end else begin
        old_sync = m_sync[c];
        old_filt = m_filt[c];
        new_filt = old_filt;
        for (int ch = 0; ch < 4; ch++) begin
          if (m_n[c] == 0) begin
            new_filt[ch] = old_sync[ch];
          end else if (old_sync[ch] != old_filt[ch]) begin
            run[c][ch] = run[c][ch] + 1;
            if (run[c][ch] == m_n[c]) begin
              new_filt[ch] = old_sync[ch];
              run[c][ch]   = 0;
            end
          end else begin
            run[c][ch] = 0;
          end
        end
        for (int k = 3; k > 0; k--) hist[c][k] = hist[c][k-1];
        hist[c][0] = async_in;
        m_sync[c] = hist[c][m_s[c]-1];
        m_rise[c] = new_filt & ~old_filt;
        m_fall[c] = ~new_filt & old_filt;
        m_filt[c] = new_filt;
      end
    end
  end

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    logic [3:0] er, ef;
    er = EDGE_EN ? m_rise[0] : 4'b0000;
    ef = EDGE_EN ? m_fall[0] : 4'b0000;
    chk({tag, " f.sync"}, sync_f, m_sync[0]);
    chk({tag, " f.filt"}, filt_f, m_filt[0]);
    chk({tag, " f.rise"}, rise_f, er);
    chk({tag, " f.fall"}, fall_f, ef);
    chk({tag, " f.chg"}, {3'b000, chg_f}, {3'b000, |(er | ef)});
    er = EDGE_EN ? m_rise[1] : 4'b0000;
    ef = EDGE_EN ? m_fall[1] : 4'b0000;
    chk({tag, " b.sync"}, sync_b, m_sync[1]);
    chk({tag, " b.filt"}, filt_b, m_filt[1]);
    chk({tag, " b.rise"}, rise_b, er);
    chk({tag, " b.fall"}, fall_b, ef);
    chk({tag, " b.chg"}, {3'b000, chg_b}, {3'b000, |(er | ef)});
  endtask

  // Drive at the falling edge, let one rising edge pass, check at the next falling edge.
  task automatic step(input logic [3:0] v, input string tag);
    async_in = v;
    @(posedge clk);
    @(negedge clk);
    check_model(tag);
  endtask

  typedef struct {
    logic [3:0] in;
    logic [3:0] sync;
    logic [3:0] filt;
    logic [3:0] rise;
    logic [3:0] fall;
  } vec_t;

  vec_t tbl [24];

  initial begin
    logic [3:0] cur;
    int         n_chg;
    int         lat;
    bit         seen;

    // ch0 rises and is held; then a 3-cycle ch2 glitch is rejected and a 4-cycle one passes.
    tbl[0]  = '{4'b1011, 4'b1010, 4'b1010, 4'b0000, 4'b0000};
    tbl[1]  = '{4'b1011, 4'b1011, 4'b1010, 4'b0000, 4'b0000};
    tbl[2]  = '{4'b1011, 4'b1011, 4'b1010, 4'b0000, 4'b0000};
    tbl[3]  = '{4'b1011, 4'b1011, 4'b1010, 4'b0000, 4'b0000};
    tbl[4]  = '{4'b1011, 4'b1011, 4'b1010, 4'b0000, 4'b0000};
    tbl[5]  = '{4'b1011, 4'b1011, 4'b1011, 4'b0001, 4'b0000};
    tbl[6]  = '{4'b1011, 4'b1011, 4'b1011, 4'b0000, 4'b0000};
    tbl[7]  = '{4'b1111, 4'b1011, 4'b1011, 4'b0000, 4'b0000};
    tbl[8]  = '{4'b1111, 4'b1111, 4'b1011, 4'b0000, 4'b0000};
    tbl[9]  = '{4'b1111, 4'b1111, 4'b1011, 4'b0000, 4'b0000};
    tbl[10] = '{4'b1011, 4'b1111, 4'b1011, 4'b0000, 4'b0000};
    tbl[11] = '{4'b1011, 4'b1011, 4'b1011, 4'b0000, 4'b0000};
    tbl[12] = '{4'b1011, 4'b1011, 4'b1011, 4'b0000, 4'b0000};
    tbl[13] = '{4'b1111, 4'b1011, 4'b1011, 4'b0000, 4'b0000};
    tbl[14] = '{4'b1111, 4'b1111, 4'b1011, 4'b0000, 4'b0000};
    tbl[15] = '{4'b1111, 4'b1111, 4'b1011, 4'b0000, 4'b0000};
    tbl[16] = '{4'b1111, 4'b1111, 4'b1011, 4'b0000, 4'b0000};
    tbl[17] = '{4'b1011, 4'b1111, 4'b1011, 4'b0000, 4'b0000};
    tbl[18] = '{4'b1011, 4'b1011, 4'b1111, 4'b0100, 4'b0000};
    tbl[19] = '{4'b1011, 4'b1011, 4'b1111, 4'b0000, 4'b0000};
    tbl[20] = '{4'b1011, 4'b1011, 4'b1111, 4'b0000, 4'b0000};
    tbl[21] = '{4'b1011, 4'b1011, 4'b1111, 4'b0000, 4'b0000};
    tbl[22] = '{4'b1011, 4'b1011, 4'b1011, 4'b0000, 4'b0100};
    tbl[23] = '{4'b1011, 4'b1011, 4'b1011, 4'b0000, 4'b0000};

    rst_n    = 1'b0;
    async_in = 4'b1010;

    // Reset held: outputs at reset value, pulses low.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst sync", sync_f, 4'b1010);
    chk("rst filt", filt_f, 4'b1010);
    chk("rst rise", rise_f, 4'b0000);
    chk("rst fall", fall_f, 4'b0000);
    chk("rst chg", {3'b000, chg_f}, 4'b0000);
    check_model("rst");
    rst_n = 1'b1;
    step(4'b1010, "post-rst");
    chk("post-rst filt", filt_f, 4'b1010);
    chk("post-rst chg", {3'b000, chg_f}, 4'b0000);

    for (int i = 0; i < 24; i++) begin
      step(tbl[i].in, "tbl");
      chk($sformatf("tbl%0d sync", i), sync_f, tbl[i].sync);
      chk($sformatf("tbl%0d filt", i), filt_f, tbl[i].filt);
      chk($sformatf("tbl%0d rise", i), rise_f, EDGE_EN ? tbl[i].rise : 4'b0000);
      chk($sformatf("tbl%0d fall", i), fall_f, EDGE_EN ? tbl[i].fall : 4'b0000);
    end

    // ch2 rises and ch1 falls on the same edge: one shared change cycle.
    n_chg = 0;
    for (int i = 0; i < 9; i++) begin
      step(4'b1101, "simul");
      if (chg_f) begin
        n_chg++;
        chk("simul rise", rise_f, 4'b0100);
        chk("simul fall", fall_f, 4'b0010);
      end
    end
    chk("simul count", 4'(n_chg), EDGE_EN ? 4'd1 : 4'd0);
    chk("simul filt", filt_f, 4'b1101);

    // ch3 falls, reset hits after two counted disagreements.
    step(4'b0101, "midrst");
    step(4'b0101, "midrst");
    step(4'b0101, "midrst");
    step(4'b0101, "midrst");
    #2 rst_n = 1'b0;
    #1;
    chk("midrst filt", filt_f, 4'b1010);
    chk("midrst sync", sync_f, 4'b1010);
    chk("midrst chg", {3'b000, chg_f}, 4'b0000);
    check_model("midrst-async");
    @(negedge clk);
    rst_n = 1'b1;
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(4'b0101, "restart");
      lat++;
      if (filt_f == 4'b0101) seen = 1'b1;
    end
    chk("restart latency", 4'(lat), 4'd6);

    // Randomised traffic with slow toggles so many runs cross the filter threshold.
    cur = 4'b0101;
    for (int i = 0; i < 600; i++) begin
      for (int ch = 0; ch < 4; ch++) begin
        if ($urandom_range(0, 5) == 0) cur[ch] = ~cur[ch];
      end
      if (i == 300) begin
        #3 rst_n = 1'b0;
        #1 check_model("rnd-rst");
        @(negedge clk);
        rst_n = 1'b1;
      end
      step(cur, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
